// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: scanner state encoding, 50 MHz timing defaults
// and the GRB wire-order packing helper.
package ws2812_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_LATCH = 2'd3
  } ws2812_state_e;

  localparam int unsigned T_BIT_50M   = 63;
  localparam int unsigned T0H_50M     = 20;
  localparam int unsigned T1H_50M     = 40;
  localparam int unsigned T_RESET_50M = 15000;
  localparam int unsigned GRB_BITS    = 24;

  // WS2812 expects green first, then red, then blue, each MSB first.
  function automatic logic [23:0] grb_pack(input logic [7:0] r,
                                           input logic [7:0] g,
                                           input logic [7:0] b);
    return {g, r, b};
  endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// Turns one data bit into a T_BIT-cycle WS2812 pulse. Restarting on the cycle
// that o_bit_last is high gives a gap-free stream of back-to-back bits.
module ws2812_bit_encoder
  import ws2812_pkg::*;
#(
  parameter int unsigned T_BIT = T_BIT_50M,
  parameter int unsigned T0H   = T0H_50M,
  parameter int unsigned T1H   = T1H_50M
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  input  logic i_bit,
  output logic o_dout,
  output logic o_bit_last
);

  localparam int unsigned CW = (T_BIT > 1) ? $clog2(T_BIT) : 1;
  localparam logic [CW-1:0] PHASE_LAST = CW'(T_BIT - 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_high;
  logic          r_active;
  logic          r_dout;

  // Bit-phase counter and registered pulse output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_high   <= '0;
      r_active <= 1'b0;
      r_dout   <= 1'b0;
    end else if (i_start) begin
      r_cnt    <= '0;
      r_high   <= i_bit ? CW'(T1H) : CW'(T0H);
      r_active <= 1'b1;
      r_dout   <= 1'b1;
    end else if (r_active) begin
      if (r_cnt == PHASE_LAST) begin
        r_cnt    <= '0;
        r_active <= 1'b0;
        r_dout   <= 1'b0;
      end else begin
        r_cnt  <= r_cnt + CW'(1);
        r_dout <= ((r_cnt + CW'(1)) < r_high);
      end
    end else begin
      r_dout <= 1'b0;
    end
  end

  assign o_dout     = r_dout;
  assign o_bit_last = r_active && (r_cnt == PHASE_LAST);

endmodule

// File: rtl/ws2812_frame_scanner.sv
// Walks the framebuffer (optionally serpentine), serializes each pixel as GRB
// through the bit encoder, then holds the line low for the latch period.
module ws2812_frame_scanner
  import ws2812_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned HEIGTH     = 16,
  parameter bit          SERPENTINE = 1'b1,
  parameter int unsigned T_BIT      = T_BIT_50M,
  parameter int unsigned T0H        = T0H_50M,
  parameter int unsigned T1H        = T1H_50M,
  parameter int unsigned T_RESET    = T_RESET_50M
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [7:0] row,
  output logic [7:0] column,
  input  logic [7:0] r_in,
  input  logic [7:0] g_in,
  input  logic [7:0] b_in,
  output logic       dout,
  output logic       busy,
  output logic       done
);

  localparam int unsigned LW = (T_RESET > 1) ? $clog2(T_RESET) : 1;
  localparam logic [LW-1:0] LATCH_LAST = LW'(T_RESET - 1);
  localparam logic [7:0]    COL_LAST   = 8'(WIDTH - 1);
  localparam logic [7:0]    ROW_LAST   = 8'(HEIGTH - 1);

  ws2812_state_e r_state;
  ws2812_state_e w_state_nxt;

  logic [22:0]   r_shift;
  logic [4:0]    r_bit_idx;
  logic [7:0]    r_row;
  logic [7:0]    r_col;
  logic [LW-1:0] r_latch_cnt;
  logic          r_final;
  logic          r_busy;
  logic          r_done;

  logic [23:0]   w_grb;
  logic          w_row_rev;
  logic          w_row_end;
  logic          w_last_px;
  logic          w_latch_end;
  logic          w_enc_start;
  logic          w_enc_bit;
  logic          w_bit_last;
  logic          w_dout;

  assign w_grb       = grb_pack(r_in, g_in, b_in);
  assign w_row_rev   = SERPENTINE && r_row[0];
  assign w_row_end   = w_row_rev ? (r_col == 8'd0) : (r_col == COL_LAST);
  assign w_last_px   = w_row_end && (r_row == ROW_LAST);
  assign w_latch_end = (r_latch_cnt == LATCH_LAST);

  ws2812_bit_encoder #(
    .T_BIT (T_BIT),
    .T0H   (T0H),
    .T1H   (T1H)
  ) u_bit_encoder (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_enc_start),
    .i_bit      (w_enc_bit),
    .o_dout     (w_dout),
    .o_bit_last (w_bit_last)
  );

  // Frame state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and encoder launch; a new bit starts exactly as the previous ends.
  always_comb begin
    w_state_nxt = r_state;
    w_enc_start = 1'b0;
    w_enc_bit   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_FETCH;
        else       w_state_nxt = ST_IDLE;
      end
      ST_FETCH: begin
        w_state_nxt = ST_SEND;
        w_enc_start = 1'b1;
        w_enc_bit   = w_grb[23];
      end
      ST_SEND: begin
        if (!w_bit_last) begin
          w_state_nxt = ST_SEND;
        end else if (r_bit_idx != 5'd0) begin
          w_enc_start = 1'b1;
          w_enc_bit   = r_shift[22];
        end else if (r_final) begin
          w_state_nxt = ST_LATCH;
        end else begin
          w_enc_start = 1'b1;
          w_enc_bit   = w_grb[23];
        end
      end
      ST_LATCH: begin
        if (w_latch_end) w_state_nxt = ST_IDLE;
        else             w_state_nxt = ST_LATCH;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Shift register, address sequencer, latch counter and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift     <= 23'd0;
      r_bit_idx   <= 5'd0;
      r_row       <= 8'd0;
      r_col       <= 8'd0;
      r_latch_cnt <= '0;
      r_final     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != ST_IDLE);
      r_done <= (r_state == ST_LATCH) && (w_state_nxt == ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          r_row       <= 8'd0;
          r_col       <= 8'd0;
          r_latch_cnt <= '0;
          r_final     <= 1'b0;
        end
        ST_FETCH: begin
          r_shift   <= w_grb[22:0];
          r_bit_idx <= 5'd23;
          r_final   <= 1'b0;
        end
        ST_SEND: begin
          if (w_bit_last) begin
            if (r_bit_idx == 5'd0) begin
              if (!r_final) begin
                r_shift   <= w_grb[22:0];
                r_bit_idx <= 5'd23;
              end
            end else begin
              r_shift   <= {r_shift[21:0], 1'b0};
              r_bit_idx <= r_bit_idx - 5'd1;
              // Bit 0 is starting: point at the next pixel, or remember this was the last.
              if (r_bit_idx == 5'd1) begin
                if (w_last_px) begin
                  r_final <= 1'b1;
                end else if (w_row_end) begin
                  r_row <= r_row + 8'd1;
                  r_col <= (SERPENTINE && !r_row[0]) ? COL_LAST : 8'd0;
                end else if (w_row_rev) begin
                  r_col <= r_col - 8'd1;
                end else begin
                  r_col <= r_col + 8'd1;
                end
              end
            end
          end
        end
        ST_LATCH: begin
          if (w_latch_end) begin
            r_latch_cnt <= '0;
            r_row       <= 8'd0;
            r_col       <= 8'd0;
          end else begin
            r_latch_cnt <= r_latch_cnt + LW'(1);
          end
        end
        default: begin
          r_row <= 8'd0;
          r_col <= 8'd0;
        end
      endcase
    end
  end

  assign row    = r_row;
  assign column = r_col;
  assign dout   = w_dout;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_ws2812_frame_scanner.sv
// Bench for ws2812_frame_scanner: two small matrices (serpentine 2x2, linear 3x2)
// checked cycle by cycle against a scan-order / bit-stream model.
`timescale 1ns/1ps
module tb_ws2812_frame_scanner;

  localparam int TB = 63;
  localparam int T0 = 20;
  localparam int T1 = 40;
  localparam int TR = 500;
  localparam int AW = 2;
  localparam int AH = 2;
  localparam int BW = 3;
  localparam int BH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;

  logic [7:0] a_row, a_col, a_r, a_g, a_b;
  logic [7:0] b_row, b_col, b_r, b_g, b_b;
  logic       a_dout, a_busy, a_done;
  logic       b_dout, b_busy, b_done;

  logic [23:0] fb_a [0:AW*AH-1];
  logic [23:0] fb_b [0:BW*BH-1];

  int vectors = 0;
  int miscompares = 0;
  int sel = 0;

  logic       m_dout, m_busy, m_done;
  logic [7:0] m_row, m_col;

  always #5 clk = ~clk;

  ws2812_frame_scanner #(
    .WIDTH(AW), .HEIGTH(AH), .SERPENTINE(1'b1),
    .T_BIT(TB), .T0H(T0), .T1H(T1), .T_RESET(TR)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
    .row(a_row), .column(a_col),
    .r_in(a_r), .g_in(a_g), .b_in(a_b),
    .dout(a_dout), .busy(a_busy), .done(a_done)
  );

  ws2812_frame_scanner #(
    .WIDTH(BW), .HEIGTH(BH), .SERPENTINE(1'b0),
    .T_BIT(TB), .T0H(T0), .T1H(T1), .T_RESET(TR)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .row(b_row), .column(b_col),
    .r_in(b_r), .g_in(b_g), .b_in(b_b),
    .dout(b_dout), .busy(b_busy), .done(b_done)
  );

  // Framebuffers: combinational read, words stored as {r,g,b}.
  always_comb begin
    if (a_row < 8'(AH) && a_col < 8'(AW)) {a_r, a_g, a_b} = fb_a[int'(a_row) * AW + int'(a_col)];
    else {a_r, a_g, a_b} = 24'h0;
    if (b_row < 8'(BH) && b_col < 8'(BW)) {b_r, b_g, b_b} = fb_b[int'(b_row) * BW + int'(b_col)];
    else {b_r, b_g, b_b} = 24'h0;
  end

  always_comb begin
    if (sel == 1) begin
      m_dout = b_dout; m_busy = b_busy; m_done = b_done; m_row = b_row; m_col = b_col;
    end else begin
      m_dout = a_dout; m_busy = a_busy; m_done = a_done; m_row = a_row; m_col = a_col;
    end
  end

  task automatic drive_start(input int s, input logic v);
    if (s == 1) start_b = v;
    else        start_a = v;
  endtask

  // Runs one frame on the selected DUT and checks it against the model.
  // With inject, start is pulsed mid-frame and held across the done edge.
  task automatic run_frame(input int s, input bit inject);
    int w, h, n, len, hi_cnt, bad;
    bit serp, latch_bad, busy_bad, done_bad;
    logic [23:0] word;
    bit exp_bits[$];
    int exp_row[$];
    int exp_col[$];
    sel  = s;
    w    = (s == 1) ? BW : AW;
    h    = (s == 1) ? BH : AH;
    serp = (s != 1);
    n    = w * h;
    for (int p = 0; p < n; p++) begin
      int rr, cc;
      rr = p / w;
      cc = p % w;
      if (serp && (rr % 2 == 1)) cc = w - 1 - cc;
      exp_row.push_back(rr);
      exp_col.push_back(cc);
      word = (s == 1) ? fb_b[rr * w + cc] : fb_a[rr * w + cc];
      for (int i = 7; i >= 0; i--) exp_bits.push_back(word[8 + i]);
      for (int i = 7; i >= 0; i--) exp_bits.push_back(word[16 + i]);
      for (int i = 7; i >= 0; i--) exp_bits.push_back(word[i]);
    end
    len = 1 + 24 * n * TB + TR;

    drive_start(s, 1'b1);
    @(posedge clk); #1;
    drive_start(s, 1'b0);
    vectors++;
    if (m_busy !== 1'b1 || m_done !== 1'b0 || m_row !== 8'd0 || m_col !== 8'd0)
      begin miscompares++; $display("FAIL accept dut=%0d busy=%b done=%b row=%0d col=%0d exp busy=1 done=0 row=0 col=0", s, m_busy, m_done, m_row, m_col); end

    hi_cnt = 0; bad = 0; latch_bad = 0; busy_bad = 0; done_bad = 0;
    for (int cyc = 1; cyc <= len; cyc++) begin
      @(posedge clk); #1;
      if (cyc <= 24 * n * TB) begin
        int bn, ph, th;
        bn = (cyc - 1) / TB;
        ph = (cyc - 1) % TB;
        th = exp_bits[bn] ? T1 : T0;
        if (m_dout !== ((ph < th) ? 1'b1 : 1'b0)) bad++;
        if (m_dout === 1'b1) hi_cnt++;
        if (ph == TB - 1) begin
          vectors++;
          if (bad != 0) begin
            miscompares++;
            $display("FAIL bit_wave dut=%0d bit=%0d got_high=%0d bad_cycles=%0d exp_high=%0d", s, bn, hi_cnt, bad, th);
          end
          hi_cnt = 0; bad = 0;
          if (((bn + 1) % 24 == 0) && ((bn + 1) / 24 < n)) begin
            int p;
            p = (bn + 1) / 24;
            vectors++;
            if (m_row !== 8'(exp_row[p]) || m_col !== 8'(exp_col[p]))
              begin miscompares++; $display("FAIL address dut=%0d pixel=%0d got=(%0d,%0d) exp=(%0d,%0d)", s, p, m_row, m_col, exp_row[p], exp_col[p]); end
          end
        end
      end else if (cyc < len) begin
        if (m_dout !== 1'b0 || m_row !== 8'(exp_row[n-1]) || m_col !== 8'(exp_col[n-1])) latch_bad = 1;
      end
      if (cyc < len) begin
        if (m_busy !== 1'b1) busy_bad = 1;
        if (m_done !== 1'b0) done_bad = 1;
      end
      if (inject && cyc == 100) drive_start(s, 1'b1);
      if (inject && cyc == 101) drive_start(s, 1'b0);
      if (inject && cyc == len - 1) drive_start(s, 1'b1);
    end

    vectors++;
    if (latch_bad) begin miscompares++; $display("FAIL latch_hold dut=%0d got dout/address changed during latch exp dout=0 address held", s); end
    vectors++;
    if (busy_bad) begin miscompares++; $display("FAIL busy_frame dut=%0d got busy low inside frame exp busy=1", s); end
    vectors++;
    if (done_bad) begin miscompares++; $display("FAIL done_early dut=%0d got done before cycle %0d exp done=0", s, len); end
    vectors++;
    if (m_done !== 1'b1 || m_busy !== 1'b0 || m_dout !== 1'b0 || m_row !== 8'd0 || m_col !== 8'd0)
      begin miscompares++; $display("FAIL frame_end dut=%0d done=%b busy=%b dout=%b row=%0d col=%0d exp 1 0 0 0 0", s, m_done, m_busy, m_dout, m_row, m_col); end
    if (!inject) begin
      @(posedge clk); #1;
      vectors++;
      if (m_done !== 1'b0 || m_busy !== 1'b0)
        begin miscompares++; $display("FAIL done_width dut=%0d done=%b busy=%b exp done=0 busy=0", s, m_done, m_busy); end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start_a = 1'b1; start_b = 1'b1;
    repeat (3) @(posedge clk); #1;
    vectors++;
    if (a_dout !== 1'b0 || a_busy !== 1'b0 || a_done !== 1'b0 || a_row !== 8'd0 || a_col !== 8'd0)
      begin miscompares++; $display("FAIL reset_a dout=%b busy=%b done=%b row=%0d col=%0d exp all 0", a_dout, a_busy, a_done, a_row, a_col); end
    vectors++;
    if (b_dout !== 1'b0 || b_busy !== 1'b0 || b_done !== 1'b0 || b_row !== 8'd0 || b_col !== 8'd0)
      begin miscompares++; $display("FAIL reset_b dout=%b busy=%b done=%b row=%0d col=%0d exp all 0", b_dout, b_busy, b_done, b_row, b_col); end
    start_a = 1'b0; start_b = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk); #1;
    vectors++;
    if (a_busy !== 1'b0 || a_dout !== 1'b0 || b_busy !== 1'b0 || b_dout !== 1'b0)
      begin miscompares++; $display("FAIL idle_hold busy_a=%b dout_a=%b busy_b=%b dout_b=%b exp all 0", a_busy, a_dout, b_busy, b_dout); end
  endtask

  task automatic test_frame_serp;
    for (int i = 0; i < AW * AH; i++) fb_a[i] = 24'($urandom);
    fb_a[0] = {8'hFF, 8'h00, 8'h00};
    run_frame(0, 1'b0);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < AW * AH; i++) fb_a[i] = 24'($urandom);
    run_frame(0, 1'b1);
    run_frame(0, 1'b0);
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < AW * AH; i++) fb_a[i] = 24'($urandom);
    sel = 0;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (24 * TB + 4) @(posedge clk);
    #1;
    vectors++;
    if (a_dout !== 1'b1 || a_busy !== 1'b1 || a_row !== 8'd0 || a_col !== 8'd1)
      begin miscompares++; $display("FAIL pre_reset dout=%b busy=%b row=%0d col=%0d exp dout=1 busy=1 row=0 col=1", a_dout, a_busy, a_row, a_col); end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (a_dout !== 1'b0 || a_busy !== 1'b0 || a_done !== 1'b0 || a_row !== 8'd0 || a_col !== 8'd0)
      begin miscompares++; $display("FAIL mid_reset dout=%b busy=%b done=%b row=%0d col=%0d exp all 0", a_dout, a_busy, a_done, a_row, a_col); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame(0, 1'b0);
  endtask

  task automatic test_serp0;
    for (int i = 0; i < BW * BH; i++) fb_b[i] = {8'h00, 8'hAA, 8'h00};
    run_frame(1, 1'b0);
  endtask

  task automatic test_random_linear;
    for (int i = 0; i < BW * BH; i++) fb_b[i] = 24'($urandom);
    run_frame(1, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < AW * AH; i++) fb_a[i] = 24'h0;
    for (int i = 0; i < BW * BH; i++) fb_b[i] = 24'h0;
    test_reset();
    test_frame_serp();
    test_back_to_back();
    test_reset_mid();
    test_serp0();
    test_random_linear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
